// File: rtl/fir_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sequencer_if
//  Description : Bundle between the FIR control sequencer and its datapath /
//                outside world.
//                  dr, lc     - synchronized data_ready / load_coeff
//                  overflow   - ALU signed overflow of the op in flight
//                  op         - ALU micro-op code
//                  src1, src2 - register-file operand addresses
//                  dest       - register-file write-back address
//                  cnt_up     - one-cycle strobe per accepted sample
//                  clear      - one-cycle clear of the sample counter
//                  modwait    - busy handshake (registered)
//                  err        - error flag (registered)
//                master = sequencer side, slave = datapath / environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_sequencer_if #(
    parameter int REG_ADDR_BITS = 4,
    parameter int OP_BITS       = 3
);
    logic                     dr;
    logic                     lc;
    logic                     overflow;
    logic [OP_BITS-1:0]       op;
    logic [REG_ADDR_BITS-1:0] src1;
    logic [REG_ADDR_BITS-1:0] src2;
    logic [REG_ADDR_BITS-1:0] dest;
    logic                     cnt_up;
    logic                     clear;
    logic                     modwait;
    logic                     err;

    modport master (
        input  dr, lc, overflow,
        output op, src1, src2, dest, cnt_up, clear, modwait, err
    );

    modport slave (
        output dr, lc, overflow,
        input  op, src1, src2, dest, cnt_up, clear, modwait, err
    );
endinterface
`default_nettype wire

// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sequencer
//  Description : Control FSM for the 4-tap FIR datapath. Issues one register
//                file / ALU micro-op per clock to compute
//                  R0 = R1*F0 - R2*F1 + R3*F2 - R4*F3
//                and loads coefficients F0..F3 into R5..R8.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous, active-high reset
//                bus   - fir_sequencer_if.master (dr, lc, overflow in;
//                        op, src1, src2, dest, cnt_up, clear, modwait, err out)
//  Register map: R0 accumulator, R1..R4 sample history (R1 newest),
//                R5..R8 coefficients, R9 product temp, R10 incoming sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sequencer #(
    parameter int REG_ADDR_BITS = 4,
    parameter int OP_BITS       = 3
) (
    input wire logic        clk,
    input wire logic        reset,
    fir_sequencer_if.master bus
);

    localparam logic [OP_BITS-1:0] c_OP_NOP   = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] c_OP_COPY  = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] c_OP_LOAD1 = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] c_OP_LOAD2 = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] c_OP_ADD   = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] c_OP_SUB   = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] c_OP_MUL   = OP_BITS'(6);

    localparam logic [REG_ADDR_BITS-1:0] c_R0  = REG_ADDR_BITS'(0);
    localparam logic [REG_ADDR_BITS-1:0] c_R1  = REG_ADDR_BITS'(1);
    localparam logic [REG_ADDR_BITS-1:0] c_R2  = REG_ADDR_BITS'(2);
    localparam logic [REG_ADDR_BITS-1:0] c_R3  = REG_ADDR_BITS'(3);
    localparam logic [REG_ADDR_BITS-1:0] c_R4  = REG_ADDR_BITS'(4);
    localparam logic [REG_ADDR_BITS-1:0] c_R5  = REG_ADDR_BITS'(5);
    localparam logic [REG_ADDR_BITS-1:0] c_R6  = REG_ADDR_BITS'(6);
    localparam logic [REG_ADDR_BITS-1:0] c_R7  = REG_ADDR_BITS'(7);
    localparam logic [REG_ADDR_BITS-1:0] c_R8  = REG_ADDR_BITS'(8);
    localparam logic [REG_ADDR_BITS-1:0] c_R9  = REG_ADDR_BITS'(9);
    localparam logic [REG_ADDR_BITS-1:0] c_R10 = REG_ADDR_BITS'(10);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_STORE  = 5'd1,
        ST_SHIFT3 = 5'd2,
        ST_SHIFT2 = 5'd3,
        ST_SHIFT1 = 5'd4,
        ST_LOADN  = 5'd5,
        ST_MUL0   = 5'd6,
        ST_COPY0  = 5'd7,
        ST_MUL1   = 5'd8,
        ST_SUB1   = 5'd9,
        ST_MUL2   = 5'd10,
        ST_ADD2   = 5'd11,
        ST_MUL3   = 5'd12,
        ST_SUB3   = 5'd13,
        ST_LDCOEF = 5'd14,
        ST_WAITLC = 5'd15,
        ST_EIDLE  = 5'd16
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [1:0]               r_coef_idx;
    logic                     r_modwait;
    logic                     r_err;

    logic [OP_BITS-1:0]       w_op;
    logic [REG_ADDR_BITS-1:0] w_src1;
    logic [REG_ADDR_BITS-1:0] w_src2;
    logic [REG_ADDR_BITS-1:0] w_dest;
    logic                     w_cnt_up;
    logic                     w_clear;
    logic [REG_ADDR_BITS-1:0] w_coef_dest;

    // Coefficient slot: index wraps at 4, so a fifth load overwrites F0.
    assign w_coef_dest = c_R5 + REG_ADDR_BITS'(r_coef_idx);

    // State, coefficient index and the registered handshake outputs.
    // modwait/err are decoded from the next state so they change on the
    // same edge that enters the corresponding state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_coef_idx <= 2'd0;
            r_modwait  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_modwait <= (w_next != ST_IDLE) && (w_next != ST_EIDLE) &&
                         (w_next != ST_WAITLC);
            r_err     <= (w_next == ST_EIDLE);
            if (r_state == ST_LDCOEF) begin
                r_coef_idx <= r_coef_idx + 2'd1;
            end
        end
    end

    // Next-state and Moore micro-op decode.
    always_comb begin
        w_next   = r_state;
        w_op     = c_OP_NOP;
        w_src1   = c_R0;
        w_src2   = c_R0;
        w_dest   = c_R0;
        w_cnt_up = 1'b0;
        w_clear  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.dr)      w_next = ST_STORE;
                else if (bus.lc) w_next = ST_LDCOEF;
            end
            ST_STORE: begin
                w_op   = c_OP_LOAD1;
                w_dest = c_R10;
                // dr gone already: the sample was withdrawn before capture.
                w_next = bus.dr ? ST_SHIFT3 : ST_EIDLE;
            end
            ST_SHIFT3: begin
                w_op     = c_OP_COPY;
                w_src1   = c_R3;
                w_dest   = c_R4;
                w_cnt_up = 1'b1;
                w_next   = ST_SHIFT2;
            end
            ST_SHIFT2: begin
                w_op = c_OP_COPY; w_src1 = c_R2; w_dest = c_R3; w_next = ST_SHIFT1;
            end
            ST_SHIFT1: begin
                w_op = c_OP_COPY; w_src1 = c_R1; w_dest = c_R2; w_next = ST_LOADN;
            end
            ST_LOADN: begin
                w_op = c_OP_COPY; w_src1 = c_R10; w_dest = c_R1; w_next = ST_MUL0;
            end
            ST_MUL0: begin
                w_op = c_OP_MUL; w_src1 = c_R1; w_src2 = c_R5; w_dest = c_R9;
                w_next = ST_COPY0;
            end
            ST_COPY0: begin
                w_op = c_OP_COPY; w_src1 = c_R9; w_dest = c_R0; w_next = ST_MUL1;
            end
            ST_MUL1: begin
                w_op = c_OP_MUL; w_src1 = c_R2; w_src2 = c_R6; w_dest = c_R9;
                w_next = ST_SUB1;
            end
            ST_SUB1: begin
                w_op = c_OP_SUB; w_src1 = c_R0; w_src2 = c_R9; w_dest = c_R0;
                w_next = bus.overflow ? ST_EIDLE : ST_MUL2;
            end
            ST_MUL2: begin
                w_op = c_OP_MUL; w_src1 = c_R3; w_src2 = c_R7; w_dest = c_R9;
                w_next = ST_ADD2;
            end
            ST_ADD2: begin
                w_op = c_OP_ADD; w_src1 = c_R0; w_src2 = c_R9; w_dest = c_R0;
                w_next = bus.overflow ? ST_EIDLE : ST_MUL3;
            end
            ST_MUL3: begin
                w_op = c_OP_MUL; w_src1 = c_R4; w_src2 = c_R8; w_dest = c_R9;
                w_next = ST_SUB3;
            end
            ST_SUB3: begin
                w_op = c_OP_SUB; w_src1 = c_R0; w_src2 = c_R9; w_dest = c_R0;
                w_next = bus.overflow ? ST_EIDLE : ST_IDLE;
            end
            ST_LDCOEF: begin
                w_op    = c_OP_LOAD2;
                w_dest  = w_coef_dest;
                // First coefficient of a set restarts the sample counter.
                w_clear = (r_coef_idx == 2'd0);
                w_next  = bus.lc ? ST_WAITLC : ST_IDLE;
            end
            ST_WAITLC: begin
                // Swallow a long lc pulse so one pulse loads one coefficient.
                if (bus.dr)       w_next = ST_STORE;
                else if (!bus.lc) w_next = ST_IDLE;
            end
            ST_EIDLE: begin
                if (bus.dr)      w_next = ST_STORE;
                else if (bus.lc) w_next = ST_LDCOEF;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.op      = w_op;
    assign bus.src1    = w_src1;
    assign bus.src2    = w_src2;
    assign bus.dest    = w_dest;
    assign bus.cnt_up  = w_cnt_up;
    assign bus.clear   = w_clear;
    assign bus.modwait = r_modwait;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_sequencer
//  Description : Self-checking bench for fir_sequencer. Per-cycle stimulus
//                records carry the inputs for one clock edge and the outputs
//                expected after it; expectations are queued when the inputs
//                are driven and popped/compared at the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;

    localparam int REG_ADDR_BITS = 4;
    localparam int OP_BITS       = 3;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] COPY  = 3'd1;
    localparam logic [2:0] LOAD1 = 3'd2;
    localparam logic [2:0] LOAD2 = 3'd3;
    localparam logic [2:0] ADD   = 3'd4;
    localparam logic [2:0] SUB   = 3'd5;
    localparam logic [2:0] MUL   = 3'd6;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
        logic       cnt_up;
        logic       clear;
        logic       modwait;
        logic       err;
    } out_t;

    typedef struct packed {
        logic       dr;
        logic       lc;
        logic       ovf;
        out_t       exp;
        logic [7:0] tag;
    } vec_t;

    logic tb_clk = 1'b0;
    logic tb_reset;
    int   checks = 0;
    int   errors = 0;
    int   model_idx;
    vec_t vecs[$];
    out_t exp_q[$];

    fir_sequencer_if #(.REG_ADDR_BITS(REG_ADDR_BITS), .OP_BITS(OP_BITS)) bus ();

    fir_sequencer #(.REG_ADDR_BITS(REG_ADDR_BITS), .OP_BITS(OP_BITS)) dut (
        .clk   (tb_clk),
        .reset (tb_reset),
        .bus   (bus.master)
    );

    always #5 tb_clk = ~tb_clk;

    function automatic out_t mk(input logic [2:0] op, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] d,
                                input logic cu, input logic cl,
                                input logic mw, input logic er);
        mk = {op, s1, s2, d, cu, cl, mw, er};
    endfunction

    function automatic out_t actual();
        actual = {bus.op, bus.src1, bus.src2, bus.dest,
                  bus.cnt_up, bus.clear, bus.modwait, bus.err};
    endfunction

    // Expected outputs in each state of a clean sample, step k = 1..14
    // (STORE .. SUB3, then back in IDLE).
    function automatic out_t sample_step(input int k);
        case (k)
            1:  sample_step = mk(LOAD1, 0, 0, 10, 0, 0, 1, 0);
            2:  sample_step = mk(COPY,  3, 0,  4, 1, 0, 1, 0);
            3:  sample_step = mk(COPY,  2, 0,  3, 0, 0, 1, 0);
            4:  sample_step = mk(COPY,  1, 0,  2, 0, 0, 1, 0);
            5:  sample_step = mk(COPY, 10, 0,  1, 0, 0, 1, 0);
            6:  sample_step = mk(MUL,   1, 5,  9, 0, 0, 1, 0);
            7:  sample_step = mk(COPY,  9, 0,  0, 0, 0, 1, 0);
            8:  sample_step = mk(MUL,   2, 6,  9, 0, 0, 1, 0);
            9:  sample_step = mk(SUB,   0, 9,  0, 0, 0, 1, 0);
            10: sample_step = mk(MUL,   3, 7,  9, 0, 0, 1, 0);
            11: sample_step = mk(ADD,   0, 9,  0, 0, 0, 1, 0);
            12: sample_step = mk(MUL,   4, 8,  9, 0, 0, 1, 0);
            13: sample_step = mk(SUB,   0, 9,  0, 0, 0, 1, 0);
            default: sample_step = mk(NOP, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t got;
        got = actual();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got op=%0d s1=%0d s2=%0d d=%0d cu=%b cl=%b mw=%b err=%b, expected op=%0d s1=%0d s2=%0d d=%0d cu=%b cl=%b mw=%b err=%b",
                     name, got.op, got.src1, got.src2, got.dest, got.cnt_up,
                     got.clear, got.modwait, got.err, exp.op, exp.src1,
                     exp.src2, exp.dest, exp.cnt_up, exp.clear, exp.modwait,
                     exp.err);
        end
    endtask

    task automatic push_vec(input logic dr, input logic lc, input logic ovf,
                            input out_t exp, input logic [7:0] tag);
        vec_t v;
        v.dr = dr; v.lc = lc; v.ovf = ovf; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    // One sample: dr held for the IDLE and STORE edges. ovf_k selects the
    // step whose input edge sees overflow=1 (0 = none); only the edges
    // leaving SUB1 (10), ADD2 (12) and SUB3 (14) divert to EIDLE.
    task automatic push_sample(input int ovf_k, input logic lc_all,
                               input logic [7:0] tag);
        for (int k = 1; k <= 14; k++) begin
            if ((k == ovf_k) && (k == 10 || k == 12 || k == 14)) begin
                push_vec(1'b0, lc_all, 1'b1, mk(NOP, 0, 0, 0, 0, 0, 0, 1), tag);
                return;
            end
            push_vec(k <= 2, lc_all, k == ovf_k, sample_step(k), tag);
        end
    endtask

    // Edge entering LDCOEF; lc is the input presented on that edge.
    task automatic push_ld(input logic [7:0] tag);
        push_vec(1'b0, 1'b1, 1'b0,
                 mk(LOAD2, 0, 0, 4'(5 + model_idx), 0, model_idx == 0, 1, 0), tag);
        model_idx = (model_idx + 1) % 4;
    endtask

    task automatic push_lc_pulse(input logic [7:0] tag);
        push_ld(tag);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), tag);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            out_t e;
            bus.dr       = vecs[i].dr;
            bus.lc       = vecs[i].lc;
            bus.overflow = vecs[i].ovf;
            exp_q.push_back(vecs[i].exp);
            @(negedge tb_clk);
            e = exp_q.pop_front();
            check_out($sformatf("vec%0d_tag%0d", i, vecs[i].tag), e);
        end
        vecs.delete();
        bus.dr = 1'b0; bus.lc = 1'b0; bus.overflow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    initial begin
        tb_reset     = 1'b1;
        bus.dr       = 1'b0;
        bus.lc       = 1'b0;
        bus.overflow = 1'b0;
        model_idx    = 0;

        // ---------------- stimulus table ----------------
        // tag 1: four coefficients (0x4000, 0x8000, 0x8000, 0x4000) -> R5..R8
        for (int i = 0; i < 4; i++) push_lc_pulse(8'd1);
        // tag 2: four samples of 100
        for (int i = 0; i < 4; i++) push_sample(0, 1'b0, 8'd2);
        // tag 3: early drop, err held in EIDLE, next sample clears it
        push_vec(1'b1, 1'b0, 1'b0, sample_step(1), 8'd3);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 1), 8'd3);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 1), 8'd3);
        push_sample(0, 1'b0, 8'd3);
        // tag 4: overflow in ADD2, then coefficient load from EIDLE (5th -> R5)
        push_sample(12, 1'b0, 8'd4);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 1), 8'd4);
        push_lc_pulse(8'd4);
        // tag 5: overflow ignored in MUL0; honoured in SUB1 and SUB3
        push_sample(7, 1'b0, 8'd5);
        push_sample(10, 1'b0, 8'd5);
        push_sample(14, 1'b0, 8'd5);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 1), 8'd5);
        push_sample(0, 1'b0, 8'd5);
        // tag 6: dr+lc together -> sample first, lc then taken from IDLE
        push_sample(0, 1'b1, 8'd6);
        push_lc_pulse(8'd6);
        // tag 7: long lc parks in WAITLC; dr from WAITLC starts a sample
        push_ld(8'd7);
        push_vec(1'b0, 1'b1, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), 8'd7);
        push_vec(1'b0, 1'b1, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), 8'd7);
        push_sample(0, 1'b1, 8'd7);
        push_ld(8'd7);
        push_vec(1'b0, 1'b1, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), 8'd7);
        push_vec(1'b0, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0, 0, 0), 8'd7);

        // ---------------- reset state ----------------
        repeat (2) @(negedge tb_clk);
        check_out("reset_hold", mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        tb_reset = 1'b0;
        @(negedge tb_clk);
        check_out("after_reset_idle", mk(NOP, 0, 0, 0, 0, 0, 0, 0));

        run_vecs();

        // ---------------- asynchronous reset in MUL1 ----------------
        bus.dr = 1'b1;
        repeat (2) @(negedge tb_clk);
        bus.dr = 1'b0;
        repeat (6) @(negedge tb_clk);
        check_out("pre_reset_mul1", sample_step(8));
        #2 tb_reset = 1'b1;
        #1 check_out("reset_async_same_cycle", mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        @(negedge tb_clk);
        tb_reset = 1'b0;
        check_out("reset_held_edge", mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        model_idx = 0;
        push_sample(0, 1'b0, 8'd8);
        push_lc_pulse(8'd8);
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control FSM for the 4-tap FIR datapath: the 16-entry register file, the ALU and the sample counter.
- Accepts a new sample (dr) or a coefficient (lc), both from upstream synchronizers, and issues one datapath micro-op per clock to compute fir_out = R1*F0 - R2*F1 + R3*F2 - R4*F3.
- Drives the modwait handshake and the err flag to the outside world, plus count/clear strobes to the one_k_samples counter.

Parameters:
- REG_ADDR_BITS, 4, register-file address width (16 registers).
- OP_BITS, 3, ALU op-code width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dr  in  1  synchronized data_ready.
- lc  in  1  synchronized load_coeff.
- overflow  in  1  ALU signed overflow of the current op, combinational from datapath.
- op  out  OP_BITS  0 NOP, 1 COPY, 2 LOAD1 (sample), 3 LOAD2 (coeff), 4 ADD, 5 SUB, 6 MUL.
- src1  out  REG_ADDR_BITS  ALU operand 1 address.
- src2  out  REG_ADDR_BITS  ALU operand 2 address.
- dest  out  REG_ADDR_BITS  write-back address.
- cnt_up  out  1  one-cycle strobe per accepted sample.
- clear  out  1  one-cycle clear of sample counter.
- modwait  out  1  busy, registered.
- err  out  1  error flag, registered.

Behaviour:
- Register map: R0 accumulator/result, R1..R4 sample history (R1 newest), R5..R8 coefficients F0..F3, R9 product temp, R10 incoming sample.
- Reset (asynchronous, any time, including mid-sequence): state=IDLE, coefficient index=0, modwait=0, err=0. Combinational outputs follow IDLE: op=NOP, src/dest=0, cnt_up=0, clear=0.
- Outputs op/src1/src2/dest/cnt_up/clear are Moore (decoded from current state).
- modwait and err are registered from next state:
  - modwait=1 for any next state except IDLE, EIDLE and WAITLC.
  - err=1 iff next state is EIDLE.
- States, written as state: outputs -> next:
  - IDLE: NOP. dr=1 -> STORE; else lc=1 -> LDCOEF; else IDLE. dr has priority over lc.
  - STORE: LOAD1 dest R10. dr=0 -> EIDLE (sample dropped early); else SHIFT3.
  - SHIFT3: COPY R4<-R3, cnt_up=1 -> SHIFT2.
  - SHIFT2: COPY R3<-R2 -> SHIFT1.
  - SHIFT1: COPY R2<-R1 -> LOADN.
  - LOADN: COPY R1<-R10 -> MUL0.
  - MUL0: R9=R1*R5 -> COPY0.
  - COPY0: R0<-R9 -> MUL1.
  - MUL1: R9=R2*R6 -> SUB1.
  - SUB1: R0=R0-R9. overflow -> EIDLE; else MUL2.
  - MUL2: R9=R3*R7 -> ADD2.
  - ADD2: R0=R0+R9. overflow -> EIDLE; else MUL3.
  - MUL3: R9=R4*R8 -> SUB3.
  - SUB3: R0=R0-R9. overflow -> EIDLE; else IDLE.
  - LDCOEF: LOAD2 dest R(5+idx); clear=1 when idx==0; idx<=idx+1 (2-bit, wraps, so a 5th coeff overwrites F0). Next: lc=1 -> WAITLC; else IDLE.
  - WAITLC: NOP, ignore lc. lc=0 -> IDLE; dr=1 -> STORE (dr priority).
  - EIDLE: NOP, err held 1. dr=1 -> STORE (err drops on that edge); lc=1 -> LDCOEF; else EIDLE.
- Latency: clock edge entering STORE raises modwait. A clean sample holds modwait high 13 cycles (STORE..SUB3), and modwait falls on the edge entering IDLE; R0 is valid then.
- Coefficient load: modwait high exactly 1 cycle per coefficient.
- Overflow is sampled only in SUB1/ADD2/SUB3 and ignored in all other states. The faulting op's write-back still occurs; R0 content is undefined after an error.
- dr and lc both high in IDLE: sample processed, lc ignored; if lc is still high afterwards it is taken from IDLE.
- dr re-asserted while busy: ignored until IDLE/EIDLE/WAITLC.

Test Plan:
- Reset mid-sequence: pulse reset in MUL1 -> same cycle modwait=0, err=0, op=NOP; next dr runs a full 13-cycle sequence.
- Coefficient load: lc pulses with 0x4000, 0x8000, 0x8000, 0x4000 -> LOAD2 dest 5, 6, 7, 8 in order; clear=1 only on the first; modwait 1 cycle each.
- Sample stream: dr held until modwait rises, four samples of 100 -> exact op/src/dest trace per state; cnt_up one pulse per sample; modwait high 13 cycles; err=0.
- Early drop: dr high 1 cycle only (low in STORE) -> EIDLE, err=1, modwait=0; next valid dr clears err on entry to STORE.
- Overflow: force overflow=1 in ADD2 -> EIDLE next edge, err=1, MUL3/SUB3 never issued; force overflow=1 in MUL0 -> ignored.
- Priority/wrap: dr and lc together in IDLE -> STORE taken; fifth coefficient load -> dest R5 again, clear=1.
